// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready handshakes on both sides.
// Optional accumulator feedback operand is enabled by defining LOGIC_ACC_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_allone
);

  typedef enum logic [OPW-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] result;
  logic             s1_adv;
  logic             s2_adv;
  logic             in_xfer;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_y_q,     s1_y_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_y_q,     s2_y_d;
  logic             s2_zero_q,  s2_zero_d;
  logic             s2_par_q,   s2_par_d;
  logic             s2_one_q,   s2_one_d;

  assign op = op_e'(in_op);

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid && s1_adv;

`ifdef LOGIC_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;

  assign a_eff = in_acc ? acc_q : in_a;
  assign acc_d = in_xfer ? result : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`else
  logic unused_acc;

  assign a_eff      = in_a;
  assign unused_acc = in_acc;
`endif

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a_eff & in_b;
      OP_OR:   result = a_eff | in_b;
      OP_NAND: result = ~(a_eff & in_b);
      OP_NOR:  result = ~(a_eff | in_b);
      OP_XOR:  result = a_eff ^ in_b;
      OP_XNOR: result = ~(a_eff ^ in_b);
      OP_NOT:  result = ~a_eff;
      OP_PASS: result = a_eff;
      default: result = '0;
    endcase
  end

  // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latch).
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_zero_d  = s2_zero_q;
    s2_par_d   = s2_par_q;
    s2_one_d   = s2_one_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_y_d     = result;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Data and flags load only with a valid S1 beat, so bubbles leave them untouched.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_y_d    = s1_y_q;
        s2_zero_d = (s1_y_q == '0);
        s2_par_d  = ^s1_y_q;
        s2_one_d  = &s1_y_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_zero_q  <= 1'b0;
      s2_par_q   <= 1'b0;
      s2_one_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_y_q     <= s1_y_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_zero_q  <= s2_zero_d;
      s2_par_q   <= s2_par_d;
      s2_one_q   <= s2_one_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_y      = s2_y_q;
  assign out_zero   = s2_zero_q;
  assign out_parity = s2_par_q;
  assign out_allone = s2_one_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed op/flag/backpressure/reset/accumulator
// scenarios plus randomized valid/ready traffic checked against a reference model.
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic             allone;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_parity;
  logic             out_allone;

  exp_t             sb_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [WIDTH-1:0] model_acc;
  bit               stalled = 1'b0;
  logic [WIDTH+3:0] held;
  bit               rand_done;

  logic_unit_pipe #(.WIDTH(WIDTH), .OPW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_parity(out_parity),
    .out_allone(out_allone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t flags_of(input logic [WIDTH-1:0] y);
    exp_t r;
    r.y      = y;
    r.zero   = (y == 0);
    r.parity = ($countones(y) % 2) == 1;
    r.allone = (y == {WIDTH{1'b1}});
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until accepted; pushes either the given constant or the model result.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                      input logic acc, input exp_t e, input bit use_model);
    int               budget = 0;
    bit               took;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] y;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = acc;
    forever begin
      @(negedge clk);
      took = in_ready;
      if (took) begin
        a_eff = a;
`ifdef LOGIC_ACC_EN
        if (acc) a_eff = model_acc;
`endif
        y         = ref_op(op, a_eff, b);
        model_acc = y;
        sb_q.push_back(use_model ? flags_of(y) : e);
      end
      @(posedge clk);
      if (took) break;
      budget++;
      if (budget > 500) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (sb_q.size() != 0 && b < 500) begin
      @(posedge clk);
      b++;
    end
    #1;
    check("drain_left", sb_q.size(), 0);
  endtask

  // Monitor: pops on every output transfer and checks that a stalled beat holds still.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", {out_valid, out_y, out_zero, out_parity, out_allone}, held);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", {out_y, out_zero, out_parity, out_allone}, 32'hDEAD);
        end else begin
          check("beat", {out_y, out_zero, out_parity, out_allone}, sb_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_valid, out_y, out_zero, out_parity, out_allone};
    end
  end

  initial begin
    logic [7:0] sweep_exp [8];
    sweep_exp = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_acc    = 1'b0;
    out_ready = 1'b1;
    model_acc = '0;
    #12;
    check("reset_outputs", {out_valid, out_y, out_zero, out_parity, out_allone}, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    step(1);

    // Op sweep, back to back.
    for (int op = 0; op < 8; op++)
      send(8'hF0, 8'h3C, op[2:0], 1'b0, flags_of(sweep_exp[op]), 1'b0);
    drain();

    // Flag corners.
    send(8'h0F, 8'hF0, 3'd0, 1'b0, exp_t'{8'h00, 1'b1, 1'b0, 1'b0}, 1'b0);
    send(8'h0F, 8'hF0, 3'd1, 1'b0, exp_t'{8'hFF, 1'b0, 1'b0, 1'b1}, 1'b0);
    send(8'h01, 8'h00, 3'd7, 1'b0, exp_t'{8'h01, 1'b0, 1'b1, 1'b0}, 1'b0);
    drain();

    // Backpressure.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(i[7:0], 8'hFF, 3'd4, 1'b0, flags_of(8'hFF - i[7:0]), 1'b0);
      end
      begin
        step(5);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_y", {out_valid, out_y}, {1'b1, 8'hFF});
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), exp_t'(0), 1'b1);
          if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step(1);
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-stream with both stages full.
    out_ready = 1'b0;
    send(8'hAA, 8'h00, 3'd7, 1'b0, exp_t'(0), 1'b1);
    send(8'h55, 8'h00, 3'd7, 1'b0, exp_t'(0), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {out_valid, out_y, out_zero, out_parity, out_allone}, 0);
    check("rst_in_ready", in_ready, 1);
    sb_q.delete();
    model_acc = '0;
    step(1);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h5A;
    in_b      = 8'h0F;
    in_op     = 3'd4;
    in_acc    = 1'b0;
    sb_q.push_back(flags_of(8'h55));
    model_acc = 8'h55;
    step(1);
    in_valid = 1'b0;
    check("lat_cycle1", out_valid, 0);
    step(1);
    check("lat_cycle2", out_valid, 1);
    drain();

    // Accumulator chain, in_acc=1 with a=0.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_acc = '0;
    step(1);
`ifdef LOGIC_ACC_EN
    send(8'h00, 8'h01, 3'd1, 1'b1, flags_of(8'h01), 1'b0);
    send(8'h00, 8'h02, 3'd1, 1'b1, flags_of(8'h03), 1'b0);
    send(8'h00, 8'hFF, 3'd4, 1'b1, flags_of(8'hFC), 1'b0);
    send(8'h00, 8'h00, 3'd6, 1'b1, flags_of(8'h03), 1'b0);
`else
    send(8'h00, 8'h01, 3'd1, 1'b1, flags_of(8'h01), 1'b0);
    send(8'h00, 8'h02, 3'd1, 1'b1, flags_of(8'h02), 1'b0);
    send(8'h00, 8'hFF, 3'd4, 1'b1, flags_of(8'hFF), 1'b0);
    send(8'h00, 8'h00, 3'd6, 1'b1, flags_of(8'hFF), 1'b0);
`endif
    drain();
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
